// File: rtl/score_seg_scanner_pkg.sv
// Shared constants and helpers for the breakout score display.
// Holds the seven-segment encoder and point clamping.
package score_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         DIGITS_MAX = 8;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 goes dark
    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (bcd)
            4'd0: pat = 7'b1000000;
            4'd1: pat = 7'b1111001;
            4'd2: pat = 7'b0100100;
            4'd3: pat = 7'b0110000;
            4'd4: pat = 7'b0011001;
            4'd5: pat = 7'b0010010;
            4'd6: pat = 7'b0000010;
            4'd7: pat = 7'b1111000;
            4'd8: pat = 7'b0000000;
            4'd9: pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Non-BCD point values are treated as 9
    function automatic logic [3:0] clamp_pts(input logic [3:0] pts);
        return (pts > 4'd9) ? 4'd9 : pts;
    endfunction

endpackage

// File: rtl/score_seg_scanner_if.sv
// Bundle between collision logic / board pins and the score scanner.
// master drives hit/pts/clear/pause, slave drives score and display.
interface score_seg_scanner_if #(
    parameter int DIGITS = 4
) ();
    logic                  clear;
    logic                  hit;
    logic [3:0]            pts;
    logic                  pause;
    logic [4*DIGITS-1:0]   score_bcd;
    logic                  saturated;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output clear, hit, pts, pause,
        input  score_bcd, saturated, seg, an
    );

    modport slave (
        input  clear, hit, pts, pause,
        output score_bcd, saturated, seg, an
    );
endinterface

// File: rtl/score_seg_scanner_bcd_digit_add.sv
// One BCD digit of the score ripple adder.
// Inputs are assumed to be valid BCD digits.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw;

    // Binary add, then fold results above 9 back into one BCD digit
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        cout = (raw > 5'd9);
        sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
    end
endmodule

// File: rtl/score_seg_scanner.sv
// Saturating BCD score register plus common-anode scan driver.
// Scan runs off a clock-enable prescaler; an/seg are registered.
module score_seg_scanner
    import score_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    score_seg_scanner_if.slave   bus
);
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(SCAN_DIV);
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [4*DIGITS-1:0] score;
    logic                sat;
    logic [4*DIGITS-1:0] sum;
    logic [DIGITS:0]     carry;
    logic [3:0]          add_pts;
    logic                all_nines;

    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic                tick_q;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS-1:0]   upper_zero;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;

    assign add_pts   = clamp_pts(bus.pts);
    assign carry[0]  = 1'b0;
    assign all_nines = (score == ALL_NINES);

    // Full-width ripple; only the ones digit receives the points
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] b_g;
        if (g == 0) begin : g_lsd
            assign b_g = add_pts;
        end else begin : g_hi
            assign b_g = 4'd0;
        end
        bcd_digit_add u_add (
            .a    (score[4*g +: 4]),
            .b    (b_g),
            .cin  (carry[g]),
            .sum  (sum[4*g +: 4]),
            .cout (carry[g+1])
        );
    end

    // Score register: clear wins, then unpaused hits; overflow pins at all 9s
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
            sat   <= 1'b0;
        end else if (bus.clear) begin
            score <= '0;
            sat   <= 1'b0;
        end else if (bus.hit && !bus.pause) begin
            if (all_nines) begin
                sat <= 1'b1;
            end else if (carry[DIGITS]) begin
                score <= ALL_NINES;
                sat   <= 1'b1;
            end else begin
                score <= sum;
            end
        end
    end

    assign tick = (cnt == CNT_LAST);

    // Prescaler producing one tick every SCAN_DIV clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // Digit index advances on tick; tick_q triggers the display refresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Pick the current digit, blanking it when it is a leading zero
    always_comb begin
        logic z;
        z          = 1'b1;
        upper_zero = '0;
        an_d       = '1;
        seg_d      = SEG_BLANK;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z             = z & (score[4*i +: 4] == 4'd0);
            upper_zero[i] = z;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx) begin
                if (!((BLANK_LZ != 0) && (i != 0) && upper_zero[i])) begin
                    an_d[i] = 1'b0;
                    seg_d   = seg_encode(score[4*i +: 4]);
                end
            end
        end
    end

    // Registered pin drivers, refreshed the cycle after each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else if (tick_q) begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.score_bcd = score;
    assign bus.saturated = sat;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
endmodule

// File: tb/tb_score_seg_scanner.sv
// Directed bench for score_seg_scanner with SCAN_DIV=4, four digits.
// A second instance with BLANK_LZ=0 shares all stimulus.
module tb_score_seg_scanner;
    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   fails;

    score_seg_scanner_if #(.DIGITS(4)) bus1 ();
    score_seg_scanner_if #(.DIGITS(4)) bus2 ();

    assign bus2.clear = bus1.clear;
    assign bus2.hit   = bus1.hit;
    assign bus2.pts   = bus1.pts;
    assign bus2.pause = bus1.pause;

    score_seg_scanner #(
        .DIGITS(4), .CLK_HZ(4), .SCAN_HZ(1), .BLANK_LZ(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    score_seg_scanner #(
        .DIGITS(4), .CLK_HZ(4), .SCAN_HZ(1), .BLANK_LZ(0)
    ) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hits(input int n, input logic [3:0] p);
        bus1.hit = 1'b1;
        bus1.pts = p;
        repeat (n) step();
        bus1.hit = 1'b0;
        bus1.pts = 4'd0;
    endtask

    task automatic do_clear();
        bus1.clear = 1'b1;
        step();
        bus1.clear = 1'b0;
    endtask

    function automatic logic [3:0] an_of(input int sel);
        return (sel != 0) ? bus2.an : bus1.an;
    endfunction

    // Wait (bounded) until an of the selected DUT equals/differs from v
    task automatic wait_an(input int sel, input logic [3:0] v,
                           input bit want_eq, input string tag);
        int n;
        n = 0;
        while (((an_of(sel) == v) != want_eq) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check(tag, 32'(an_of(sel)), 32'(v));
    endtask

    task automatic sync_digit0(input int sel, input string tag);
        wait_an(sel, 4'b1110, 1'b0, tag);
        wait_an(sel, 4'b1110, 1'b1, tag);
    endtask

    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        rst        = 1'b1;
        bus1.clear = 1'b0;
        bus1.hit   = 1'b0;
        bus1.pts   = 4'd0;
        bus1.pause = 1'b0;
        #12;
        check("rst_score", 32'(bus1.score_bcd), 32'h0);
        check("rst_sat", 32'(bus1.saturated), 32'h0);
        check("rst_an", 32'(bus1.an), 32'hF);
        check("rst_seg", 32'(bus1.seg), 32'h7F);
        rst = 1'b0;
        step();

        // 1: ten hits of 7
        hits(10, 4'd7);
        check("t1_score", 32'(bus1.score_bcd), 32'h0070);
        check("t1_sat", 32'(bus1.saturated), 32'h0);

        // 2: saturation at 9999
        do_clear();
        hits(1110, 4'd9);
        hits(1, 4'd5);
        check("t2_preload", 32'(bus1.score_bcd), 32'h9995);
        check("t2_presat", 32'(bus1.saturated), 32'h0);
        hits(1, 4'd9);
        check("t2_ovf_score", 32'(bus1.score_bcd), 32'h9999);
        check("t2_ovf_sat", 32'(bus1.saturated), 32'h1);
        hits(1, 4'd1);
        check("t2_hold_score", 32'(bus1.score_bcd), 32'h9999);
        check("t2_hold_sat", 32'(bus1.saturated), 32'h1);
        do_clear();
        check("t2_clr_score", 32'(bus1.score_bcd), 32'h0);
        check("t2_clr_sat", 32'(bus1.saturated), 32'h0);

        // 3: clear priority, clamping, pause
        hits(1, 4'd3);
        bus1.clear = 1'b1;
        bus1.hit   = 1'b1;
        bus1.pts   = 4'd5;
        step();
        bus1.clear = 1'b0;
        bus1.hit   = 1'b0;
        check("t3_clr_vs_hit", 32'(bus1.score_bcd), 32'h0);
        hits(1, 4'hF);
        check("t3_clamp", 32'(bus1.score_bcd), 32'h0009);
        bus1.pause = 1'b1;
        hits(1, 4'd3);
        bus1.pause = 1'b0;
        check("t3_pause", 32'(bus1.score_bcd), 32'h0009);
        hits(1, 4'd0);
        check("t3_pts0", 32'(bus1.score_bcd), 32'h0009);
        hits(1, 4'd3);
        check("t3_carry", 32'(bus1.score_bcd), 32'h0012);

        // 4: scanning 0042, eight steps of exactly four clocks
        do_clear();
        hits(4, 4'd9);
        hits(1, 4'd6);
        check("t4_score", 32'(bus1.score_bcd), 32'h0042);
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0100100;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b0011001;
        exp_an[2] = 4'b1111; exp_seg[2] = 7'h7F;
        exp_an[3] = 4'b1111; exp_seg[3] = 7'h7F;
        sync_digit0(0, "t4_sync");
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("t4_an_s%0d_c%0d", k, c),
                      32'(bus1.an), 32'(exp_an[k % 4]));
                check($sformatf("t4_seg_s%0d_c%0d", k, c),
                      32'(bus1.seg), 32'(exp_seg[k % 4]));
                step();
            end
        end

        // 5: zero score, blanked vs unblanked instance
        do_clear();
        sync_digit0(0, "t5_sync");
        for (int c = 0; c < 16; c++) begin
            check($sformatf("t5_an_c%0d", c), 32'(bus1.an),
                  (c < 4) ? 32'hE : 32'hF);
            check($sformatf("t5_seg_c%0d", c), 32'(bus1.seg),
                  (c < 4) ? 32'h40 : 32'h7F);
            step();
        end
        sync_digit0(1, "t5_nb_sync");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_nb_an_%0d", k), 32'(bus2.an),
                  32'(~(4'b0001 << k) & 4'hF));
            check($sformatf("t5_nb_seg_%0d", k), 32'(bus2.seg), 32'h40);
            repeat (4) step();
        end

        // 6: async reset between edges, then restart sequence
        hits(1, 4'd5);
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        check("t6_an", 32'(bus1.an), 32'hF);
        check("t6_seg", 32'(bus1.seg), 32'h7F);
        check("t6_score", 32'(bus1.score_bcd), 32'h0);
        check("t6_sat", 32'(bus1.saturated), 32'h0);
        check("t6_nb_an", 32'(bus2.an), 32'hF);
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("t6_nb_dark_%0d", c), 32'(bus2.an), 32'hF);
        end
        step();
        check("t6_nb_first", 32'(bus2.an), 32'hD);
        check("t6_nb_first_seg", 32'(bus2.seg), 32'h40);
        check("t6_blank_first", 32'(bus1.an), 32'hF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
